// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture sequencer.
// Optional build macro: TRACE_CHANGE_ONLY_EN (record only value changes).
package trace_pkg;

  localparam int unsigned TRACE_DEPTH = 1024;
  localparam int unsigned TRACE_WIDTH = 64;

  // Bit positions inside the 3-bit status word
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_TRIG = 1;
  localparam int unsigned STAT_WRAP = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    DONE,
    READ
  } trace_state_t;

endpackage

// File: rtl/trace_readout.sv
// Streams the captured window out of the BRAM: one read in flight, a one-entry
// skid register holding returned data until the host channel accepts it.
module trace_readout #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_active,
  input  logic [AW-1:0]    i_ptr,
  input  logic [AW:0]      i_count,
  input  logic             i_rd_rdy,
  output logic             o_rd_ena,
  output logic [AW-1:0]    o_rd_addr,
  input  logic [WIDTH-1:0] i_rdata,
  input  logic             i_rdata_vld,
  input  logic             i_out_rdy,
  output logic             o_out_ena,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_empty
);

  logic [AW-1:0]    r_ptr;
  logic [AW:0]      r_left;
  logic             r_pend;
  logic             r_held;
  logic [WIDTH-1:0] r_data;
  logic             w_enq;
  logic             w_arrive;

  assign w_enq    = r_held && i_out_rdy;
  assign w_arrive = r_pend && i_rdata_vld;

  // Next read may overlap the enq of the held word, so its address is one ahead.
  assign o_rd_ena  = i_active && i_rd_rdy && !r_pend && (!r_held || w_enq) &&
                     (r_left > (AW+1)'(r_held));
  assign o_rd_addr = r_held ? r_ptr + AW'(1) : r_ptr;
  assign o_out_ena  = w_enq;
  assign o_out_data = r_data;
  assign o_empty    = (r_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_left <= '0;
      r_pend <= 1'b0;
      r_held <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_ptr  <= i_ptr;
      r_left <= i_count;
      r_pend <= 1'b0;
      r_held <= 1'b0;
    end else begin
      if (o_rd_ena)      r_pend <= 1'b1;
      else if (w_arrive) r_pend <= 1'b0;
      if (w_arrive) begin
        r_held <= 1'b1;
        r_data <= i_rdata;
      end else if (w_enq) begin
        r_held <= 1'b0;
      end
      if (w_enq) begin
        r_ptr  <= r_ptr + AW'(1);
        r_left <= r_left - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace BRAM sequencer: circular pre-trigger capture, post-trigger count, oldest-first readout.
// Build macro TRACE_CHANGE_ONLY_EN: write a sample only when it differs from the last written one.
module trace_capture_ctrl
  import trace_pkg::*;
#(
  parameter  int unsigned DEPTH = TRACE_DEPTH,
  parameter  int unsigned WIDTH = TRACE_WIDTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             arm__ENA,
  output logic             arm__RDY,
  input  logic [AW-1:0]    postCount,
  input  logic             trigger,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic             bramWrite__ENA,
  output logic [AW-1:0]    bramWrite_addr,
  output logic [WIDTH-1:0] bramWrite_data,
  input  logic             bramWrite__RDY,
  output logic             bramRead__ENA,
  output logic [AW-1:0]    bramRead_addr,
  input  logic             bramRead__RDY,
  input  logic [WIDTH-1:0] bramDataOut,
  input  logic             bramDataOut__RDY,
  output logic             out__ENA,
  output logic [WIDTH-1:0] out_data,
  input  logic             out__RDY,
  output logic [2:0]       status
);

  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  trace_state_t  r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_post_cnt;
  logic [AW-1:0] r_post_left;
  logic [AW:0]   r_fill;
  logic          r_wrapped;
  logic          r_triggered;
  logic          r_arm_rdy;
  logic          w_cap;
  logic          w_arm;
  logic          w_load;
  logic          w_rd_empty;
  logic [2:0]    w_status;
`ifdef TRACE_CHANGE_ONLY_EN
  logic [WIDTH-1:0] r_last;
  logic             r_last_vld;
`endif

  assign w_arm  = arm__ENA && r_arm_rdy;
  assign w_load = (r_state == DONE) && !w_arm;

  always_comb begin
    w_cap = ((r_state == ARMED) || (r_state == POST)) && enable && bramWrite__RDY;
`ifdef TRACE_CHANGE_ONLY_EN
    if (r_last_vld && (data == r_last)) w_cap = 1'b0;
`endif
  end

  always_comb begin
    w_status            = '0;
    w_status[STAT_BUSY] = (r_state != IDLE);
    w_status[STAT_TRIG] = r_triggered;
    w_status[STAT_WRAP] = r_wrapped;
  end

  assign status         = w_status;
  assign arm__RDY       = r_arm_rdy;
  assign bramWrite__ENA = w_cap;
  assign bramWrite_addr = r_wr_ptr;
  assign bramWrite_data = w_cap ? data : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_post_cnt  <= '0;
      r_post_left <= '0;
      r_fill      <= '0;
      r_wrapped   <= 1'b0;
      r_triggered <= 1'b0;
      r_arm_rdy   <= 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
      r_last      <= '0;
      r_last_vld  <= 1'b0;
`endif
    end else begin
      if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_wr_ptr == AW'(DEPTH - 1)) r_wrapped <= 1'b1;
        if (r_fill != FILL_MAX)         r_fill    <= r_fill + (AW+1)'(1);
`ifdef TRACE_CHANGE_ONLY_EN
        r_last     <= data;
        r_last_vld <= 1'b1;
`endif
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_arm) begin
            r_state     <= ARMED;
            r_arm_rdy   <= 1'b0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_post_cnt  <= postCount;
`ifdef TRACE_CHANGE_ONLY_EN
            r_last_vld  <= 1'b0;
`endif
          end else if (r_state == DONE) begin
            r_state   <= (r_fill == '0) ? IDLE : READ;
            r_arm_rdy <= (r_fill == '0);
          end else begin
            r_arm_rdy <= 1'b1;
          end
        end
        ARMED: begin
          if (trigger) begin
            r_triggered <= 1'b1;
            r_post_left <= r_post_cnt;
            if (r_post_cnt == '0) begin
              r_state   <= DONE;
              r_arm_rdy <= 1'b1;
            end else begin
              r_state <= POST;
            end
          end
        end
        POST: begin
          // The write that exhausts the count is the last one recorded.
          if (w_cap) begin
            r_post_left <= r_post_left - AW'(1);
            if (r_post_left == AW'(1)) begin
              r_state   <= DONE;
              r_arm_rdy <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_rd_empty) begin
            r_state   <= IDLE;
            r_arm_rdy <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  trace_readout #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_readout (
    .clk         (CLK),
    .rst_n       (nRST),
    .i_load      (w_load),
    .i_active    (r_state == READ),
    .i_ptr       (r_wrapped ? r_wr_ptr : '0),
    .i_count     (r_fill),
    .i_rd_rdy    (bramRead__RDY),
    .o_rd_ena    (bramRead__ENA),
    .o_rd_addr   (bramRead_addr),
    .i_rdata     (bramDataOut),
    .i_rdata_vld (bramDataOut__RDY),
    .i_out_rdy   (out__RDY),
    .o_out_ena   (out__ENA),
    .o_out_data  (out_data),
    .o_empty     (w_rd_empty)
  );

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl (DEPTH=16, WIDTH=16) with a 1-cycle-latency BRAM model.
module tb_trace_capture_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        arm__ENA, arm__RDY, trigger, enable;
  logic [3:0]  postCount;
  logic [15:0] data;
  logic        bramWrite__ENA, bramWrite__RDY;
  logic [3:0]  bw_addr, br_addr;
  logic [15:0] bw_data, br_dout, out_data;
  logic        bramRead__ENA, bramRead__RDY, br_vld;
  logic        out__ENA, out__RDY;
  logic [2:0]  status;

  logic [15:0] mem [16];
  logic [15:0] got [$];
  int          nwr;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 CLK = ~CLK;

  trace_capture_ctrl #(.DEPTH(16), .WIDTH(16)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .arm__ENA         (arm__ENA),
    .arm__RDY         (arm__RDY),
    .postCount        (postCount),
    .trigger          (trigger),
    .enable           (enable),
    .data             (data),
    .bramWrite__ENA   (bramWrite__ENA),
    .bramWrite_addr   (bw_addr),
    .bramWrite_data   (bw_data),
    .bramWrite__RDY   (bramWrite__RDY),
    .bramRead__ENA    (bramRead__ENA),
    .bramRead_addr    (br_addr),
    .bramRead__RDY    (bramRead__RDY),
    .bramDataOut      (br_dout),
    .bramDataOut__RDY (br_vld),
    .out__ENA         (out__ENA),
    .out_data         (out_data),
    .out__RDY         (out__RDY),
    .status           (status)
  );

  // BRAM model plus write counter and readout scoreboard
  always @(posedge CLK) begin
    if (bramWrite__ENA) begin
      mem[bw_addr] <= bw_data;
      nwr = nwr + 1;
    end
    br_vld  <= bramRead__ENA;
    br_dout <= mem[br_addr];
    if (out__ENA) got.push_back(out_data);
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic arm(input int pc);
    arm__ENA = 1'b1; postCount = 4'(pc);
    @(posedge CLK); #1;
    arm__ENA = 1'b0;
    got.delete();
    nwr = 0;
  endtask

  task automatic sample(input int v, input bit trg);
    enable = 1'b1; data = 16'(v); trigger = trg;
    @(posedge CLK); #1;
    enable = 1'b0; trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit toggle);
    int k = 0;
    while (status[0] && k < budget) begin
      if (toggle) out__RDY = (k % 3 == 0);
      @(posedge CLK); #1;
      k++;
    end
    out__RDY = 1'b1;
    check("idle_reached", 32'(status[0]), 0);
  endtask

  int exp_n;
  int exp_w [6];

  initial begin
    nRST = 1'b0; arm__ENA = 1'b0; postCount = '0; trigger = 1'b0; enable = 1'b0;
    data = '0; bramWrite__RDY = 1'b1; bramRead__RDY = 1'b1; out__RDY = 1'b1;
    nwr = 0;
    #3;
    check("rst_status", 32'(status), 0);
    check("rst_arm_rdy", 32'(arm__RDY), 0);
    check("rst_wr_ena", 32'(bramWrite__ENA), 0);
    check("rst_out_ena", 32'(out__ENA), 0);
    @(posedge CLK); @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_arm_rdy", 32'(arm__RDY), 1);

    // trigger while idle is ignored
    trigger = 1'b1; @(posedge CLK); #1; trigger = 1'b0;
    check("idle_trig_ignored", 32'(status), 0);

    // 1: postCount=4, samples 1..10, trigger with 6
    arm(4);
    check("t1_armed_status", 32'(status), 1);
    for (int v = 1; v <= 10; v++) sample(v, v == 6);
    check("t1_done_status", 32'(status), 3);
    check("t1_done_arm_rdy", 32'(arm__RDY), 1);
    check("t1_writes", 32'(nwr), 10);
    wait_idle(200, 1'b0);
    check("t1_count", 32'(got.size()), 10);
    for (int i = 0; i < 10; i++) check("t1_word", 32'(got[i]), 32'(i + 1));
    check("t1_idle_status", 32'(status), 2);

    // 2: wrap, postCount=2, trigger at 30, host stalled then 1-of-3 ready
    out__RDY = 1'b0;
    arm(2);
    for (int v = 0; v < 40; v++) sample(v, v == 30);
    check("t2_writes", 32'(nwr), 33);
    check("t2_status", 32'(status), 7);
    check("t2_arm_ignored", 32'(arm__RDY), 0);
    check("t2_stalled", 32'(got.size()), 0);
    wait_idle(400, 1'b1);
    check("t2_count", 32'(got.size()), 16);
    for (int i = 0; i < 16; i++) check("t2_word", 32'(got[i]), 32'(17 + i));
    check("t2_idle_status", 32'(status), 6);

    // 3: postCount=0, trigger on third sample
    arm(0);
    sample(1, 1'b0); sample(2, 1'b0); sample(3, 1'b1);
    check("t3_done_status", 32'(status), 3);
    check("t3_writes", 32'(nwr), 3);
    wait_idle(100, 1'b0);
    check("t3_count", 32'(got.size()), 3);
    for (int i = 0; i < 3; i++) check("t3_word", 32'(got[i]), 32'(i + 1));

    // 4: repeated values 5,5,5,7,7,9, trigger on first
`ifdef TRACE_CHANGE_ONLY_EN
    arm(2);
    exp_n = 3; exp_w = '{5, 7, 9, 0, 0, 0};
`else
    arm(5);
    exp_n = 6; exp_w = '{5, 5, 5, 7, 7, 9};
`endif
    sample(5, 1'b1); sample(5, 1'b0); sample(5, 1'b0);
    sample(7, 1'b0); sample(7, 1'b0); sample(9, 1'b0);
    check("t4_writes", 32'(nwr), 32'(exp_n));
    wait_idle(100, 1'b0);
    check("t4_count", 32'(got.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) check("t4_word", 32'(got[i]), 32'(exp_w[i]));

    // 5: reset while a word sits in the skid register
    out__RDY = 1'b0;
    arm(3);
    for (int v = 1; v <= 4; v++) sample(v, v == 1);
    repeat (5) begin @(posedge CLK); #1; end
    check("t5_stalled_out", 32'(out__ENA), 0);
    out__RDY = 1'b1; #1;
    check("t5_out_ena", 32'(out__ENA), 1);
    check("t5_out_data", 32'(out_data), 1);
    nRST = 1'b0; #1;
    check("t5_rst_out_ena", 32'(out__ENA), 0);
    check("t5_rst_out_data", 32'(out_data), 0);
    check("t5_rst_rd_ena", 32'(bramRead__ENA), 0);
    check("t5_rst_status", 32'(status), 0);
    check("t5_rst_arm_rdy", 32'(arm__RDY), 0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    check("t5_rel_arm_rdy", 32'(arm__RDY), 1);
    check("t5_rel_status", 32'(status), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
